// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared state and side encodings for the two-way arbiter
package mux_arbiter_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT_A = 2'd1;
   localparam logic [1:0] ST_GRANT_B = 2'd2;

   // Requester side encoding, also the mux select value
   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;

   // Grant state that serves the given side
   function automatic logic [1:0] grant_state(input logic side);
      return (side == SIDE_B) ? ST_GRANT_B : ST_GRANT_A;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - requester, output and select signals of the arbiter
interface mux_arbiter_if #(
   parameter int WIDTH = 8
) ();

   logic             req_a;
   logic [WIDTH-1:0] data_a;
   logic             ack_a;
   logic             req_b;
   logic [WIDTH-1:0] data_b;
   logic             ack_b;
   logic [WIDTH-1:0] y;
   logic             y_valid;
   logic             y_ready;
   logic             sel;

   // Requesters and downstream consumer
   modport master (
      output req_a, data_a, req_b, data_b, y_ready,
      input  ack_a, ack_b, y, y_valid, sel
   );

   // Arbiter
   modport slave (
      input  req_a, data_a, req_b, data_b, y_ready,
      output ack_a, ack_b, y, y_valid, sel
   );

endinterface

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - WIDTH-bit 2:1 data mux
module mux2_w #(
   parameter int WIDTH = 8
) (
   input  logic             s,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter with hold limit and registered output
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input logic          clk,
   input logic          rst_n,
   mux_arbiter_if.slave bus
);

   localparam logic [4:0] HOLD = 5'(MAX_HOLD);

   logic [1:0]       state, state_nxt;
   logic             last, last_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [4:0]       cnt_inc;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] mux_y;
   logic             y_valid_q;
   logic             sel;
   logic             granted;
   logic             own_req;
   logic             other_req;
   logic             other_side;
   logic             idle_pick;
   logic             can_accept;
   logic             accept;

   assign sel        = (state == ST_GRANT_B);
   assign granted    = (state == ST_GRANT_A) || (state == ST_GRANT_B);
   assign own_req    = sel ? bus.req_b : bus.req_a;
   assign other_req  = sel ? bus.req_a : bus.req_b;
   assign other_side = sel ? SIDE_A : SIDE_B;
   // On a tie the side that was not served last wins
   assign idle_pick  = (bus.req_a && bus.req_b) ? ~last : bus.req_b;
   // The output slot is free when empty or being drained this cycle
   assign can_accept = !y_valid_q || bus.y_ready;
   assign accept     = granted && own_req && can_accept;
   assign cnt_inc    = {1'b0, cnt} + 5'd1;

   assign bus.ack_a   = accept && (state == ST_GRANT_A);
   assign bus.ack_b   = accept && (state == ST_GRANT_B);
   assign bus.sel     = sel;
   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;

   mux2_w #(.WIDTH(WIDTH)) u_mux (
      .s (sel),
      .a (bus.data_a),
      .b (bus.data_b),
      .y (mux_y)
   );

   // Grant selection, hand-over on drop or hold limit, beat counting
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (bus.req_a || bus.req_b) begin
               state_nxt = grant_state(idle_pick);
               last_nxt  = idle_pick;
               cnt_nxt   = 4'd0;
            end
         end
         ST_GRANT_A, ST_GRANT_B: begin
            if (!own_req) begin
               if (other_req) begin
                  state_nxt = grant_state(other_side);
                  last_nxt  = other_side;
                  cnt_nxt   = 4'd0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (accept) begin
               // Once the limit is reached a waiting requester takes over;
               // with nobody waiting the count parks at the limit
               if ((cnt_inc >= HOLD) && other_req) begin
                  state_nxt = grant_state(other_side);
                  last_nxt  = other_side;
                  cnt_nxt   = 4'd0;
               end else if (cnt_inc >= HOLD) begin
                  cnt_nxt = HOLD[3:0];
               end else begin
                  cnt_nxt = cnt_inc[3:0];
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Arbitration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         last  <= SIDE_B;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output register: load on accept, empty when drained without refill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else if (accept) begin
         y_q       <= mux_y;
         y_valid_q <= 1'b1;
      end else if (bus.y_ready) begin
         y_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - self-checking bench for mux_arbiter against a behavioural model
module tb_mux_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: owner 0 = nobody, 1 = A, 2 = B; last_side 0 = A, 1 = B
   int         m_owner;
   int         m_last;
   int         m_beats;
   bit         m_yv;
   logic [7:0] m_y;
   bit         e_ack_a;
   bit         e_ack_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_last  = 1;
      m_beats = 0;
      m_yv    = 0;
      m_y     = 8'h00;
      e_ack_a = 0;
      e_ack_b = 0;
   endtask

   task automatic grant(input int o);
      m_owner = o;
      m_last  = o - 1;
      m_beats = 0;
   endtask

   // Compare all outputs against the model in the middle of the cycle
   task automatic sample();
      @(negedge clk);
      e_ack_a = (m_owner == 1) && bus.req_a && (!m_yv || bus.y_ready);
      e_ack_b = (m_owner == 2) && bus.req_b && (!m_yv || bus.y_ready);
      chk("ack_a", bus.ack_a, e_ack_a);
      chk("ack_b", bus.ack_b, e_ack_b);
      chk("sel", bus.sel, m_owner == 2);
      chk("y_valid", bus.y_valid, m_yv);
      chk("y", bus.y, m_y);
   endtask

   // Move the model across the clock edge, then return 1 time unit after it
   task automatic advance();
      bit         ra, rb, rdy, mine, other;
      logic [7:0] da, db;
      ra  = bus.req_a;
      rb  = bus.req_b;
      da  = bus.data_a;
      db  = bus.data_b;
      rdy = bus.y_ready;
      @(posedge clk);
      if (e_ack_a) begin
         m_y = da; m_yv = 1;
      end else if (e_ack_b) begin
         m_y = db; m_yv = 1;
      end else if (rdy) begin
         m_yv = 0;
      end
      if (m_owner == 0) begin
         if (ra && rb)  grant(m_last == 0 ? 2 : 1);
         else if (ra)   grant(1);
         else if (rb)   grant(2);
      end else begin
         mine  = (m_owner == 1) ? ra : rb;
         other = (m_owner == 1) ? rb : ra;
         if (!mine) begin
            if (other) grant(3 - m_owner);
            else       m_owner = 0;
         end else if (e_ack_a || e_ack_b) begin
            m_beats++;
            if (m_beats >= MAX_HOLD && other) grant(3 - m_owner);
            else if (m_beats > MAX_HOLD)      m_beats = MAX_HOLD;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      bus.req_a   = 0;
      bus.req_b   = 0;
      bus.data_a  = 8'h00;
      bus.data_b  = 8'h00;
      bus.y_ready = 1;
      rst_n = 0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst ack_a", bus.ack_a, 0);
      chk("rst ack_b", bus.ack_b, 0);
      chk("rst sel", bus.sel, 0);
      chk("rst y_valid", bus.y_valid, 0);
      chk("rst y", bus.y, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic drive_random();
      if (bus.req_a && !e_ack_a) begin
         if ($urandom_range(0, 15) == 0) bus.req_a = 0;
      end else begin
         bus.req_a  = ($urandom_range(0, 3) != 0);
         bus.data_a = 8'($urandom);
      end
      if (bus.req_b && !e_ack_b) begin
         if ($urandom_range(0, 15) == 0) bus.req_b = 0;
      end else begin
         bus.req_b  = ($urandom_range(0, 3) != 0);
         bus.data_b = 8'($urandom);
      end
      bus.y_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      bit exp_a, exp_b;

      // Single A beat: grant after one cycle, ack next, data one edge later
      do_reset();
      bus.req_a = 1; bus.data_a = 8'h11; bus.y_ready = 1;
      sample(); chk("t1 idle ack_a", bus.ack_a, 0); advance();
      sample(); chk("t1 ack_a", bus.ack_a, 1); advance();
      bus.req_a = 0;
      sample(); chk("t1 y", bus.y, 8'h11); chk("t1 y_valid", bus.y_valid, 1); advance();
      sample(); advance();

      // Both requesting: bursts of MAX_HOLD alternate, A first out of reset
      do_reset();
      bus.req_a = 1; bus.req_b = 1; bus.data_a = 8'hA5; bus.data_b = 8'h5A;
      for (int i = 0; i < 18; i++) begin
         exp_a = (i != 0) && (((i - 1) / 4) % 2 == 0);
         exp_b = (i != 0) && (((i - 1) / 4) % 2 == 1);
         sample();
         chk("t2 ack_a", bus.ack_a, exp_a);
         chk("t2 ack_b", bus.ack_b, exp_b);
         chk("t2 sel", bus.sel, exp_b);
         advance();
      end

      // After an A grant, a tie from IDLE goes to B
      do_reset();
      bus.req_a = 1; bus.data_a = 8'h05;
      sample(); advance();
      sample(); advance();
      bus.req_a = 0;
      sample(); advance();
      bus.req_a = 1; bus.req_b = 1; bus.data_b = 8'h06;
      sample(); chk("t3 idle ack_b", bus.ack_b, 0); advance();
      sample(); chk("t3 sel", bus.sel, 1); chk("t3 ack_b", bus.ack_b, 1); advance();
      bus.req_a = 0; bus.req_b = 0;
      sample(); advance();

      // Backpressure holds y and blocks acks, release accepts same cycle
      do_reset();
      bus.req_a = 1; bus.data_a = 8'h22; bus.y_ready = 0;
      sample(); advance();
      sample(); chk("t4 first ack_a", bus.ack_a, 1); advance();
      bus.data_a = 8'h33;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("t4 stall ack_a", bus.ack_a, 0);
         chk("t4 stall y", bus.y, 8'h22);
         chk("t4 stall y_valid", bus.y_valid, 1);
         advance();
      end
      bus.y_ready = 1;
      sample(); chk("t4 release ack_a", bus.ack_a, 1); advance();
      bus.req_a = 0;
      sample(); chk("t4 new y", bus.y, 8'h33); advance();

      // A drops mid-grant while B waits: B takes over with no gap
      do_reset();
      bus.req_a = 1; bus.data_a = 8'h44;
      sample(); advance();
      sample(); advance();
      bus.req_b = 1; bus.data_b = 8'h55;
      sample(); chk("t5 ack_a", bus.ack_a, 1); advance();
      bus.req_a = 0;
      sample(); chk("t5 drop ack_a", bus.ack_a, 0); chk("t5 drop ack_b", bus.ack_b, 0); advance();
      sample(); chk("t5 sel", bus.sel, 1); chk("t5 ack_b", bus.ack_b, 1); advance();
      bus.req_b = 0;
      sample(); chk("t5 y", bus.y, 8'h55); advance();

      // Reset pulse during a B burst clears the output immediately
      do_reset();
      bus.req_b = 1; bus.data_b = 8'h66;
      sample(); advance();
      sample(); advance();
      sample(); chk("t6 y_valid", bus.y_valid, 1); advance();
      rst_n = 0;
      #1;
      chk("t6 rst y_valid", bus.y_valid, 0);
      chk("t6 rst y", bus.y, 8'h00);
      chk("t6 rst sel", bus.sel, 0);
      chk("t6 rst ack_b", bus.ack_b, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      sample(); chk("t6 idle sel", bus.sel, 0); chk("t6 idle ack_b", bus.ack_b, 0); advance();
      sample(); chk("t6 regrant sel", bus.sel, 1); chk("t6 regrant ack_b", bus.ack_b, 1); advance();

      // Randomized traffic with occasional asynchronous resets
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         sample();
         advance();
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 0;
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1;
         end
         drive_random();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the output.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive beats granted to one requester while the other is requesting; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 req_a  input  1  requester A has a beat on data_a.
REQ-006 data_a  input  WIDTH  requester A data.
REQ-007 ack_a  output  1  combinational; high in the cycle A's beat is accepted.
REQ-008 req_b  input  1  requester B has a beat on data_b.
REQ-009 data_b  input  WIDTH  requester B data.
REQ-010 ack_b  output  1  combinational; high in the cycle B's beat is accepted.
REQ-011 y  output  WIDTH  registered output data.
REQ-012 y_valid  output  1  y holds an unconsumed beat.
REQ-013 y_ready  input  1  downstream accepts y this cycle.
REQ-014 sel  output  1  mux select; 0 = A, 1 = B; high only in state GRANT_B.

Function
REQ-015 FSM states: IDLE, GRANT_A, GRANT_B; state registered.
REQ-016 Register last: side most recently granted; register cnt: 4-bit beat count within the current grant.
REQ-017 IDLE: if only req_a -> GRANT_A; if only req_b -> GRANT_B; if both -> the side not equal to last; if neither -> stay IDLE. No beat is accepted in IDLE.
REQ-018 Entering GRANT_X: last <= X, cnt <= 0.
REQ-019 Accept in GRANT_X when req_x=1 and (y_valid=0 or y_ready=1): ack_x=1, y <= data_x, y_valid <= 1, cnt <= cnt+1.
REQ-020 Latency: accepted data appears on y with y_valid=1 on the edge after the ack cycle.
REQ-021 When y_valid=1 and y_ready=1 with no accept, y_valid <= 0 on the next edge; y is unchanged.
REQ-022 When y_valid=1 and y_ready=0, y and y_valid hold; acks stay low (backpressure).
REQ-023 ack of the non-granted side is always 0; ack_a and ack_b are never high together.
REQ-024 GRANT_X with req_x=0: other side requesting -> GRANT_other; else -> IDLE.
REQ-025 GRANT_X accepting with cnt+1 = MAX_HOLD and other side requesting -> GRANT_other on the next edge; other side not requesting -> stay, cnt saturates at MAX_HOLD.
REQ-026 Switching states costs no idle cycle: the first beat of the new side may be accepted in the cycle after the switch.
REQ-027 Requester protocol: data_x is stable while req_x=1 and ack_x=0; a requester may deassert req_x without an ack, and the arbiter tolerates it.

Reset
REQ-028 While rst_n=0: state=IDLE, last=B (A wins first tie), cnt=0, y=0, y_valid=0, sel=0, ack_a=0, ack_b=0.
REQ-029 Reset assertion mid-transfer discards any beat in y; release resumes from IDLE with no spurious ack.

Structure
REQ-030 Shared package holds the state encoding (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) and the side encoding (A=0, B=1).
REQ-031 Data selection uses one sub-module, mux2_w (WIDTH-bit 2:1 mux, y = s ? b : a), driven by sel; the arbiter holds all sequential logic.

Verification
REQ-032 Reset then only req_a=1, data_a=8'h11, y_ready=1 -> GRANT_A after 1 cycle, ack_a next cycle, y=8'h11 with y_valid=1 one cycle later.
REQ-033 Both requesting continuously, y_ready=1, MAX_HOLD=4 -> A gets 4 beats, then B gets 4 beats, alternating; sel follows grant.
REQ-034 Both requesting from IDLE after an A grant (last=A) -> B granted first.
REQ-035 GRANT_A, y_valid=1, y_ready=0 for 3 cycles -> y stable, ack_a=0; y_ready=1 -> ack_a in the same cycle, new y on the next edge.
REQ-036 req_a drops mid-grant while req_b=1 -> GRANT_B next edge, B beat accepted the cycle after.
REQ-037 rst_n pulsed low for 1 cycle during a B burst -> y_valid=0, y=0 and sel=0 immediately; IDLE on release.
